// File: rtl/approxexp_horner_pipe.sv
// Fully pipelined fixed-point ApproxExp: y = ccs * P(x), P evaluated by Horner's rule,
// one stage per coefficient, runtime-programmable coefficients, valid/ready with backpressure.
module approxexp_horner_pipe #(
    parameter int W = 64,
    parameter int DEGREE = 12,
    parameter logic [(DEGREE+1)*W-1:0] COEF_INIT = {
        64'h00000004741183A3, 64'h00000036548CFC06, 64'h0000024FDCBF140A,
        64'h0000171D939DE045, 64'h0000D00CF58F6F84, 64'h000680681CF796E3,
        64'h002D82D8305B0FEA, 64'h011111110E066FD0, 64'h0555555555070F00,
        64'h155555555581FF00, 64'h400000000002B400, 64'h7FFFFFFFFFFF4800,
        64'h8000000000000000},
    parameter int AW = $clog2(DEGREE+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_val,
    output logic          din_rdy,
    input  logic [W-1:0]  x_i,
    input  logic [W-1:0]  ccs_i,
    output logic          dout_val,
    input  logic          dout_rdy,
    output logic [W-1:0]  exp_o,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_data,
    output logic          cfg_rdy
);

    localparam logic [AW-1:0] ADDR_MAX = AW'(DEGREE);

    // Q1.(W-1) product: full 2W-bit product, rescaled and truncated back to W bits.
    function automatic logic [W-1:0] mulq(input logic [W-1:0] a, input logic [W-1:0] b);
        return W'(({{W{1'b0}}, a} * {{W{1'b0}}, b}) >> (W-1));
    endfunction

    logic [W-1:0]  r_coef [0:DEGREE];
    logic [W-1:0]  r_x    [0:DEGREE-1];
    logic [W-1:0]  r_ccs  [0:DEGREE];
    logic [W-1:0]  r_z    [1:DEGREE];
    logic [DEGREE:0] r_v;
    logic          r_vf;
    logic [W-1:0]  r_exp;

    logic          w_en;
    logic          w_cfg_wr;
    logic [W-1:0]  w_z_next [1:DEGREE];

    assign w_en     = !r_vf || dout_rdy;
    assign cfg_rdy  = !(|r_v) && !r_vf;
    assign w_cfg_wr = cfg_we && cfg_rdy && (cfg_addr <= ADDR_MAX);
    assign din_rdy  = w_en;
    assign dout_val = r_vf;
    assign exp_o    = r_exp;

    // Stage s produces z_{DEGREE-s}; the first stage seeds Horner with C[DEGREE].
    genvar gi;
    for (gi = 1; gi <= DEGREE; gi++) begin : g_horner
        if (gi == 1) begin : g_first
            assign w_z_next[gi] = r_coef[DEGREE-1] - mulq(r_x[0], r_coef[DEGREE]);
        end else begin : g_rest
            assign w_z_next[gi] = r_coef[DEGREE-gi] - mulq(r_x[gi-1], r_z[gi-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= DEGREE; k++) begin
                r_coef[k] <= COEF_INIT[k*W +: W];
                r_ccs[k]  <= '0;
            end
            for (int k = 0; k < DEGREE; k++) begin
                r_x[k] <= '0;
            end
            for (int k = 1; k <= DEGREE; k++) begin
                r_z[k] <= '0;
            end
            r_v   <= '0;
            r_vf  <= 1'b0;
            r_exp <= '0;
        end else begin
            // Writes only land while the pipeline is empty, so no in-flight sample sees a mix.
            if (w_cfg_wr) begin
                r_coef[cfg_addr] <= cfg_data;
            end
            if (w_en) begin
                r_v      <= {r_v[DEGREE-1:0], din_val};
                r_vf     <= r_v[DEGREE];
                r_x[0]   <= x_i;
                r_ccs[0] <= ccs_i;
                for (int s = 1; s < DEGREE; s++) begin
                    r_x[s] <= r_x[s-1];
                end
                for (int s = 1; s <= DEGREE; s++) begin
                    r_z[s]   <= w_z_next[s];
                    r_ccs[s] <= r_ccs[s-1];
                end
                r_exp <= mulq(r_ccs[DEGREE], r_z[DEGREE]);
            end
        end
    end

endmodule
